// File: rtl/if_stage_pkg.sv
// Shared types and helpers for the instruction-fetch stage: PC width,
// default reset PC / NOP word, and the IF/ID side-band (pc, pc+4, valid).
package if_stage_pkg;

  localparam int PC_W = 32;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t         RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Everything in IF/ID except the instruction word itself.
  typedef struct packed {
    pc_t  pc;
    pc_t  pc_plus4;
    logic valid;
  } ifid_meta_t;

  localparam int META_W = $bits(ifid_meta_t);

  function automatic ifid_meta_t make_meta(input pc_t pc, input logic valid);
    ifid_meta_t m;
    m.pc       = pc;
    m.pc_plus4 = pc + pc_t'(4);
    m.valid    = valid;
    return m;
  endfunction

  // A bubble still records the PC it replaced, so downstream debug sees where it came from.
  function automatic ifid_meta_t bubble_meta(input pc_t pc);
    return make_meta(pc, 1'b0);
  endfunction

  function automatic pc_t align_pc(input pc_t addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pipe_reg.sv
// Generic pipeline register: synchronous active-low reset to a constant,
// clear-to-value (beats hold), and hold enable.
module pipe_reg #(
  parameter int                WIDTH   = 32,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             clear,
  input  logic [WIDTH-1:0] clear_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of process order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (clear) begin
      q <= clear_val;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous rom and
// loads the IF/ID register, honouring redirect > stall > normal fetch.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                BWIDTH    = 32,
  parameter int                AD_LINES  = 6,
  parameter pc_t               RESET_PC  = RESET_PC_DEF,
  parameter logic [BWIDTH-1:0] NOP_INSTR = BWIDTH'(NOP_INSTR_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic [AD_LINES-1:0] rom_addr,
  input  logic [BWIDTH-1:0]   rom_data,
  output logic [BWIDTH-1:0]   ifid_instr,
  output logic [PC_W-1:0]     ifid_pc,
  output logic [PC_W-1:0]     ifid_pc_plus4,
  output logic                ifid_valid,
  output logic                misalign_err,
  output logic                oob_err,
  output logic [31:0]         fetch_count
);

  localparam int  IFID_W     = BWIDTH + META_W;
  localparam pc_t RESET_PC_A = {RESET_PC[PC_W-1:2], 2'b00};
  localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR, pc_t'(0), pc_t'(4), 1'b0};

  pc_t               pc;
  pc_t               pc_d;
  pc_t               pc_clear_val;
  logic              pc_hold;
  logic              in_range;
  logic              fetch;
  logic              oob_fetch;
  logic              ifid_clear;
  logic [IFID_W-1:0] ifid_d;
  logic [IFID_W-1:0] ifid_clear_val;
  logic [IFID_W-1:0] ifid_q;
  ifid_meta_t        ifid_meta;

  // NOTE: every signal driven here is assigned on every pass through the
  // block, so no latch can be inferred.
  always_comb begin
    in_range       = (pc >> (AD_LINES + 2)) == '0;
    fetch          = !redirect && !stall && in_range;
    oob_fetch      = !redirect && !stall && !in_range;

    // An out-of-range PC parks until a redirect brings it back.
    pc_hold        = stall || !in_range;
    pc_d           = pc + pc_t'(4);
    pc_clear_val   = align_pc(redirect_pc);

    ifid_clear     = redirect || oob_fetch;
    ifid_clear_val = {NOP_INSTR, bubble_meta(pc)};
    ifid_d         = {rom_data, make_meta(pc, 1'b1)};
  end

  pipe_reg #(
    .WIDTH   (PC_W),
    .RST_VAL (RESET_PC_A)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .hold      (pc_hold),
    .clear     (redirect),
    .clear_val (pc_clear_val),
    .d         (pc_d),
    .q         (pc)
  );

  pipe_reg #(
    .WIDTH   (IFID_W),
    .RST_VAL (IFID_RST)
  ) u_ifid_reg (
    .clk       (clk),
    .reset     (reset),
    .hold      (stall),
    .clear     (ifid_clear),
    .clear_val (ifid_clear_val),
    .d         (ifid_d),
    .q         (ifid_q)
  );

  assign rom_addr      = pc[AD_LINES+1:2];
  assign ifid_instr    = ifid_q[IFID_W-1 -: BWIDTH];
  assign ifid_meta     = ifid_meta_t'(ifid_q[META_W-1:0]);
  assign ifid_pc       = ifid_meta.pc;
  assign ifid_pc_plus4 = ifid_meta.pc_plus4;
  assign ifid_valid    = ifid_meta.valid;

  // Sticky error flags and the fetch counter; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign_err <= 1'b0;
      oob_err      <= 1'b0;
      fetch_count  <= '0;
    end else begin
      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
        misalign_err <= 1'b1;
      end
      if (oob_fetch) begin
        oob_err <= 1'b1;
      end
      if (fetch) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
